// File: rtl/imem_resp.sv
// Instruction memory with a fixed-latency, single-outstanding read response and a preload port.
// Define IMEM_ALIGN_CHECK_EN to flag odd fetch addresses with err instead of reading the word.
module imem_resp #(
    parameter int LAT = 2,
    parameter int AW  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd,
    input  logic [15:0] addr,
    input  logic        load_en,
    input  logic [15:0] load_addr,
    input  logic [15:0] load_data,
    output logic [15:0] data_out,
    output logic        done,
    output logic        stall,
    output logic        err
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

    state_t        state;
    logic [3:0]    cnt;
    logic [15:0]   rdreg;
    logic [15:0]   mem [0:(2**AW)-1];
    logic [AW-1:0] rdidx;
    logic [AW-1:0] ldidx;
    logic          accept;
    logic          unaligned;
    logic          unused_bits;

    assign rdidx       = addr[AW:1];
    assign ldidx       = load_addr[AW:1];
    assign accept      = rd && (state != BUSY);
    assign unused_bits = ^{addr, load_addr};

`ifdef IMEM_ALIGN_CHECK_EN
    assign unaligned = addr[0];
`else
    assign unaligned = 1'b0;
`endif

    // Array has no reset; a same-edge read sees the old word because the write is non-blocking.
    always_ff @(posedge clk) begin
        if (load_en) begin
            mem[ldidx] <= load_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            rdreg    <= 16'h0000;
            data_out <= 16'h0000;
            done     <= 1'b0;
            stall    <= 1'b0;
            err      <= 1'b0;
        end else begin
            done     <= 1'b0;
            stall    <= 1'b0;
            err      <= 1'b0;
            data_out <= 16'h0000;
            if (accept) begin
                cnt <= CNT_INIT;
                if (unaligned) begin
                    rdreg <= 16'h0000;
                    state <= DONE;
                    done  <= 1'b1;
                    err   <= 1'b1;
                end else begin
                    rdreg <= mem[rdidx];
                    if (LAT == 1) begin
                        state    <= DONE;
                        done     <= 1'b1;
                        data_out <= mem[rdidx];
                    end else begin
                        state <= BUSY;
                        stall <= 1'b1;
                    end
                end
            end else if (state == BUSY) begin
                cnt <= cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state    <= DONE;
                    done     <= 1'b1;
                    data_out <= rdreg;
                end else begin
                    stall <= 1'b1;
                end
            end else begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_imem_resp.sv
// Scoreboard bench for imem_resp: reads are predicted from a word array and edge-timed deadlines,
// and a negedge monitor checks every cycle's done/data/err/stall against the queue head.
module tb_imem_resp;
    localparam int LAT   = 3;
    localparam int AW    = 8;
    localparam int DEPTH = 1 << AW;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd;
    logic [15:0] addr;
    logic        load_en;
    logic [15:0] load_addr;
    logic [15:0] load_data;
    logic [15:0] data_out;
    logic        done;
    logic        stall;
    logic        err;

    imem_resp #(.LAT(LAT), .AW(AW)) dut (
        .clk(clk),
        .rst(rst),
        .rd(rd),
        .addr(addr),
        .load_en(load_en),
        .load_addr(load_addr),
        .load_data(load_data),
        .data_out(data_out),
        .done(done),
        .stall(stall),
        .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic        err;
        int          doneEdge;
    } exp_t;

    exp_t        expq[$];
    logic [15:0] model [DEPTH];
    int          edgeNo     = 0;
    int          busyUntil  = -1;
    int          compared   = 0;
    int          mismatched = 0;

    always @(posedge clk) edgeNo++;

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h (edge %0d)", name, actual, expected, edgeNo);
        end
    endtask

    // Monitor: a read is due exactly on its deadline edge; every other cycle must be quiet.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst) begin
            checkOutput("stall", {15'b0, stall}, {15'b0, (busyUntil > edgeNo)});
            if (expq.size() > 0 && expq[0].doneEdge <= edgeNo) begin
                e = expq.pop_front();
                checkOutput("done pulse", {15'b0, done}, 16'h0001);
                checkOutput("read data", data_out, e.data);
                checkOutput("read err", {15'b0, err}, {15'b0, e.err});
            end else begin
                checkOutput("quiet done", {15'b0, done}, 16'h0000);
                checkOutput("quiet data", data_out, 16'h0000);
                checkOutput("quiet err", {15'b0, err}, 16'h0000);
            end
        end
    end

    // Drives one cycle; a read is accepted when the previous one has reached its deadline.
    task automatic applyStimulus(input logic r, input logic [15:0] a, input logic le,
                                 input logic [15:0] la, input logic [15:0] ld);
        int   k;
        exp_t e;
        @(negedge clk);
        #1;
        rd        = r;
        addr      = a;
        load_en   = le;
        load_addr = la;
        load_data = ld;
        k = edgeNo + 1;
        if (!rst && r && busyUntil < k) begin
            e.data     = model[int'(a >> 1) % DEPTH];
            e.err      = 1'b0;
            e.doneEdge = k + LAT - 1;
`ifdef IMEM_ALIGN_CHECK_EN
            if (a[0]) begin
                e.data     = 16'h0000;
                e.err      = 1'b1;
                e.doneEdge = k;
            end
`endif
            expq.push_back(e);
            busyUntil = e.doneEdge;
        end
        if (le) model[int'(la >> 1) % DEPTH] = ld;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000);
    endtask

    // Reset raised between edges must clear outputs at once and abort the read in flight.
    task automatic midCycleReset();
        @(posedge clk);
        #2;
        rst     = 1'b1;
        rd      = 1'b0;
        load_en = 1'b0;
        expq.delete();
        busyUntil = -1;
        #1;
        checkOutput("async rst done", {15'b0, done}, 16'h0000);
        checkOutput("async rst stall", {15'b0, stall}, 16'h0000);
        checkOutput("async rst data", data_out, 16'h0000);
        checkOutput("async rst err", {15'b0, err}, 16'h0000);
        @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        rd        = 1'b0;
        addr      = 16'h0000;
        load_en   = 1'b0;
        load_addr = 16'h0000;
        load_data = 16'h0000;
        @(negedge clk);
        #1;
        checkOutput("reset done", {15'b0, done}, 16'h0000);
        checkOutput("reset stall", {15'b0, stall}, 16'h0000);
        checkOutput("reset data", data_out, 16'h0000);
        checkOutput("reset err", {15'b0, err}, 16'h0000);

        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 16'h0000, 1'b1, 16'(i * 2), 16'($urandom));
        applyStimulus(1'b0, 16'h0000, 1'b1, 16'h0000, 16'h1234);
        applyStimulus(1'b0, 16'h0000, 1'b1, 16'h0002, 16'hAAAA);
        applyStimulus(1'b0, 16'h0000, 1'b1, 16'h0004, 16'h5555);
        applyStimulus(1'b0, 16'h0000, 1'b1, 16'h0006, 16'h6666);
        @(negedge clk);
        #1;
        load_en = 1'b0;
        rst     = 1'b0;

        $display("[TB] basic read of preloaded word 0");
        applyStimulus(1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000);
        idle(LAT + 2);

        $display("[TB] back-to-back reads with rd held through DONE");
        applyStimulus(1'b1, 16'h0002, 1'b0, 16'h0000, 16'h0000);
        for (int i = 0; i < LAT; i++) applyStimulus(1'b1, 16'h0004, 1'b0, 16'h0000, 16'h0000);
        idle(LAT + 2);

        $display("[TB] request during BUSY is ignored");
        applyStimulus(1'b1, 16'h0002, 1'b0, 16'h0000, 16'h0000);
        applyStimulus(1'b1, 16'h0006, 1'b0, 16'h0000, 16'h0000);
        idle(LAT + 2);

        $display("[TB] same-edge load returns old word, later read sees new word");
        applyStimulus(1'b1, 16'h0004, 1'b1, 16'h0004, 16'hFFFF);
        idle(LAT + 1);
        applyStimulus(1'b1, 16'h0004, 1'b0, 16'h0000, 16'h0000);
        idle(LAT + 2);

        $display("[TB] reset while BUSY aborts the read");
        applyStimulus(1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000);
        midCycleReset();
        idle(LAT + 2);
        applyStimulus(1'b1, 16'h0002, 1'b0, 16'h0000, 16'h0000);
        idle(LAT + 2);

        $display("[TB] address wrap and odd address");
        applyStimulus(1'b1, 16'h0202, 1'b0, 16'h0000, 16'h0000);
        idle(LAT + 2);
        applyStimulus(1'b1, 16'h0003, 1'b0, 16'h0000, 16'h0000);
        idle(LAT + 2);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 2000; i++) begin
            logic [15:0] a;
            logic [15:0] la;
            a  = 16'($urandom);
            la = ($urandom_range(0, 1) == 1) ? a : 16'($urandom);
            applyStimulus($urandom_range(0, 99) < 60, a, $urandom_range(0, 99) < 30, la, 16'($urandom));
            if ($urandom_range(0, 199) == 0) midCycleReset();
        end
        idle(LAT + 3);
        checkOutput("queue drained", 16'(expq.size()), 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/imem_resp.md
IMEM_RESP -- requirements
Module: imem_resp

Interface
REQ-001 Parameter LAT, default 2, read latency in cycles from acceptance edge to done; legal range 1..15.
REQ-002 Parameter AW, default 8, log2 of word depth; array holds 2^AW 16-bit words.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 rd  input  1  fetch read request, sampled at rising clk.
REQ-006 addr  input  16  byte address of the requested instruction; word index = addr[AW:1].
REQ-007 load_en  input  1  preload write strobe.
REQ-008 load_addr  input  16  byte address of the preload write; word index = load_addr[AW:1].
REQ-009 load_data  input  16  preload write data.
REQ-010 data_out  output  16  instruction word; valid only while done=1, else 16'h0000.
REQ-011 done  output  1  one-cycle completion pulse for the accepted read.
REQ-012 stall  output  1  high while a read is in flight and not yet done.
REQ-013 err  output  1  alignment error flag, qualified by done (see REQ-030).

Function
REQ-014 FSM states IDLE, BUSY, DONE; all outputs registered.
REQ-015 Accept: rd=1 at a rising edge while state is IDLE or DONE. rd in BUSY is ignored (no queuing).
REQ-016 On accept: capture array[addr[AW:1]] into the read register and load the 4-bit countdown with LAT-1.
REQ-017 LAT=1: go directly to DONE on the accepting edge. LAT>1: go to BUSY.
REQ-018 BUSY: decrement the counter each edge. When the counter is 1 at an edge, move to DONE.
REQ-019 done=1 only in DONE, for exactly one cycle per accepted read. done rises LAT edges after the accepting edge.
REQ-020 stall=1 exactly when state is BUSY, i.e. LAT-1 cycles per read.
REQ-021 DONE with rd=0 moves to IDLE. DONE with rd=1 accepts the new read (back-to-back, no bubble).
REQ-022 IDLE with rd=0 stays in IDLE.
REQ-023 Array capture happens at the accept edge. Later load_en writes do not change in-flight data.
REQ-024 load_en=1 writes load_data to array[load_addr[AW:1]] at the rising edge, in any state.
REQ-025 Same-edge accept and load to the same word: the read returns the old contents (read-before-write).
REQ-026 Address bits above AW are ignored. Addresses wrap modulo 2^AW words.

Reset
REQ-027 rst=1 forces asynchronously: state IDLE, counter 0, read register 0, data_out 16'h0000, done 0, stall 0, err 0.
REQ-028 Reset mid-read aborts the read; no done is produced for it. The first read after rst falls is accepted normally.
REQ-029 Array contents are not reset. They are retained across rst and are defined only after preload.

Configuration
REQ-030 Macro IMEM_ALIGN_CHECK_EN defined:
- rd accepted with addr[0]=1 goes to DONE on the next edge regardless of LAT, with stall never asserted, err=1, data_out=16'h0000.
- err equals 0 on every aligned completion and whenever done=0.
REQ-031 Macro IMEM_ALIGN_CHECK_EN not defined:
- addr[0] is ignored and unaligned reads behave as aligned reads.
- err is tied to 0.

Verification
REQ-032 Reset and outputs:
- Assert rst mid-cycle -> outputs clear immediately, without waiting for clk.
- Preload word 0 = 16'h1234, then release rst. rd=1 with addr=16'h0000 and LAT=2 -> stall=1 for 1 cycle, then done=1 with data_out=16'h1234 for 1 cycle.
REQ-033 Back-to-back reads:
- Preload addr 2 = 16'hAAAA and addr 4 = 16'h5555, LAT=3.
- Issue rd at addr 2, then rd held high at addr 4 during DONE -> done pulses 3 edges apart, data 16'hAAAA then 16'h5555, no idle cycle between.
REQ-034 Ignored request and read-before-write:
- rd asserted with addr 6 during BUSY -> ignored; exactly one done, carrying the first address's data.
- Same-edge load_en to the accepted word with 16'hFFFF -> old value returned; a subsequent read returns 16'hFFFF.
REQ-035 Reset mid-read: rst pulsed while BUSY (LAT=4) -> no done ever appears for that read. A new read after reset completes in 4 cycles.
REQ-036 Wrap and alignment:
- With AW=8, addr=16'h0202 returns the word at addr 16'h0002.
- With IMEM_ALIGN_CHECK_EN, addr=16'h0003 -> done=1, err=1, data_out=0 one edge after accept.
- Without the macro, addr=16'h0003 returns the word at addr 16'h0002 and err=0.
